wb_cmd_master: RTL and testbench
================================

# wb_cmd_master

Wishbone classic single-transfer initiator. Accepts one read or write command at a time on a valid/ready port and runs it as a Wishbone cycle. Bounds each cycle with a timeout, retries on RTY, and returns read data plus a status code as a one-cycle response pulse. It drives slave register blocks, such as the counter and PWM peripherals, from on-chip sequencers or the SPI bridge.

## Interface
- DATA_WIDTH, 32, data bus width (8/16/32/64)
- ADDR_WIDTH, 6, Wishbone address width
- SELECT_WIDTH, DATA_WIDTH/8, byte select width
- TIMEOUT_CYCLES, 16, maximum cycles per attempt without termination (≥1)
- MAX_RETRY, 3, re-issues allowed after RTY (0 = none)

Ports:
- i_clk  in  1  clock; one clock domain
- i_rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high exactly when idle
- cmd_we  in  1  1 = write
- cmd_adr  in  ADDR_WIDTH  address
- cmd_dat  in  DATA_WIDTH  write data
- cmd_sel  in  SELECT_WIDTH  byte selects
- rsp_valid  out  1  one-cycle response pulse
- rsp_dat  out  DATA_WIDTH  read data (0 for writes/failures)
- rsp_status  out  2  0 OK, 1 ERR, 2 RTY_EXHAUSTED, 3 TIMEOUT
- wb_adr_o  out  ADDR_WIDTH
- wb_dat_o  out  DATA_WIDTH
- wb_dat_i  in  DATA_WIDTH
- wb_we_o  out  1
- wb_sel_o  out  SELECT_WIDTH
- wb_stb_o  out  1
- wb_cyc_o  out  1
- wb_ack_i  in  1
- wb_err_i  in  1
- wb_rty_i  in  1

## Operation
- States: IDLE, BUS, GAP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch adr/dat/sel/we into the wb_* output registers, clear the retry count and timer, go to BUS.
- BUS:
  - cyc=stb=1 and all wb_* outputs held stable.
  - Termination is sampled each edge with priority err > rty > ack.
  - ack: latch wb_dat_i into rsp_dat (reads only; writes give 0), status OK, go to IDLE.
  - err: status ERR, go to IDLE.
  - rty with retries < MAX_RETRY: increment the retry count, go to GAP.
  - rty with retries = MAX_RETRY: status RTY_EXHAUSTED, go to IDLE.
  - No termination, with the timer reaching TIMEOUT_CYCLES-1: status TIMEOUT, go to IDLE.
- GAP:
  - cyc=stb=0 for exactly one cycle.
  - Timer cleared, then back to BUS with the same latched command.
- rsp_valid pulses for one cycle in the IDLE cycle following any BUS→IDLE exit. rsp_dat and rsp_status hold until the next response.
- There is no response backpressure; the consumer must take the pulse.
- Timer width is $clog2(TIMEOUT_CYCLES+1); retry counter width is $clog2(MAX_RETRY+1). Neither wraps; both saturate by construction.
- Termination inputs are ignored outside BUS.

## Timing
- Reset (async assert, sync release): state IDLE, cmd_ready=1, rsp_valid=0, rsp_dat=0, rsp_status=0, all wb_* outputs 0.
- Reset mid-cycle drops cyc/stb immediately with no response.
- Command accepted at edge k: cyc/stb high from k to k+1.
- Earliest termination is sampled at edge k+1. rsp_valid is high from k+1 to k+2 and cmd_ready is high in the same cycle.
- Minimum of 2 cycles per transaction.
- A new command is accepted during the rsp_valid cycle; back-to-back cycles have exactly one cycle with cyc low between them.
- Timeout: with no termination, cyc is high for exactly TIMEOUT_CYCLES cycles, then rsp_valid fires the next cycle.
- Each retry costs the 1-cycle GAP plus the new attempt, with a fresh timeout.

## Structure
- Shared package wb_pkg holds:
  - the rsp_status localparams (WB_OK, WB_ERR, WB_RTY_EXH, WB_TIMEOUT)
  - the state encoding
- Single module; no sub-module. The timer and retry counters are inline.

## Test plan
- Write, slave acks combinationally (ack=stb): cmd adr=0x04, dat=0xDEADBEEF, sel=0xF → cyc high 1 cycle, wb_dat_o=0xDEADBEEF, rsp_valid 1 cycle after, status 0, rsp_dat 0.
- Read from a free-running counter slave with 2-cycle registered ack → cyc high 3 cycles, rsp_dat equals wb_dat_i at the ack edge, status 0.
- Slave asserts rty every attempt, MAX_RETRY=3 → 4 attempts, each separated by 1 low-cyc cycle, then status 2.
- Slave asserts rty once then acks → 2 attempts, status 0.
- Silent slave, TIMEOUT_CYCLES=16 → cyc high exactly 16 cycles, status 3.
- Simultaneous ack+err gives status 1.
- i_rst_n pulsed low mid-BUS → cyc/stb drop immediately, no rsp_valid, cmd_ready=1 after release.
- Back-to-back commands with cmd_valid held high → exactly one low-cyc cycle between transfers.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pkg
//  Purpose  : Shared definitions for the Wishbone command master: response
//             status codes and the initiator state encoding.
//  Contents : WB_OK / WB_ERR / WB_RTY_EXH / WB_TIMEOUT status codes,
//             wb_state_e (IDLE, BUS, GAP).
//  Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

   // Response status codes reported on rsp_status
   localparam logic [1:0] WB_OK      = 2'd0;
   localparam logic [1:0] WB_ERR     = 2'd1;
   localparam logic [1:0] WB_RTY_EXH = 2'd2;
   localparam logic [1:0] WB_TIMEOUT = 2'd3;

   // Initiator states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_GAP  = 2'd2
   } wb_state_e;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : wb_cmd_master
//  Purpose  : Wishbone classic single-transfer initiator. Takes one read or
//             write command on a valid/ready port, runs it as a Wishbone
//             cycle with a per-attempt timeout and RTY re-issue, and returns
//             read data plus a status code as a one-cycle response pulse.
//  Ports    : i_clk, i_rst_n          clock, async active-low reset
//             cmd_valid/cmd_ready      command handshake (ready == idle)
//             cmd_we/adr/dat/sel       command fields
//             rsp_valid/dat/status     one-cycle response, fields hold
//             wb_*                     Wishbone classic initiator port
//  Revision : 1.0 - initial release
// ============================================================================
module wb_cmd_master
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 6,
   parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int MAX_RETRY      = 3
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   // command port
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_we,
   input  logic [ADDR_WIDTH-1:0]   cmd_adr,
   input  logic [DATA_WIDTH-1:0]   cmd_dat,
   input  logic [SELECT_WIDTH-1:0] cmd_sel,
   // response port
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_dat,
   output logic [1:0]              rsp_status,
   // Wishbone initiator
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   output logic                    wb_we_o,
   output logic [SELECT_WIDTH-1:0] wb_sel_o,
   output logic                    wb_stb_o,
   output logic                    wb_cyc_o,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i,
   input  logic                    wb_rty_i
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   // A zero-retry build still needs a 1-bit counter to keep the logic legal
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

   wb_state_e                 state_q,      state_d;
   logic [ADDR_WIDTH-1:0]     adr_q,        adr_d;
   logic [DATA_WIDTH-1:0]     dat_q,        dat_d;
   logic [SELECT_WIDTH-1:0]   sel_q,        sel_d;
   logic                      we_q,         we_d;
   logic [TMR_W-1:0]          timer_q,      timer_d;
   logic [RTY_W-1:0]          retry_q,      retry_d;
   logic                      rsp_valid_q,  rsp_valid_d;
   logic [DATA_WIDTH-1:0]     rsp_dat_q,    rsp_dat_d;
   logic [1:0]                rsp_status_q, rsp_status_d;

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         adr_q        <= '0;
         dat_q        <= '0;
         sel_q        <= '0;
         we_q         <= 1'b0;
         timer_q      <= '0;
         retry_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_dat_q    <= '0;
         rsp_status_q <= WB_OK;
      end else begin
         state_q      <= state_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         sel_q        <= sel_d;
         we_q         <= we_d;
         timer_q      <= timer_d;
         retry_q      <= retry_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_dat_q    <= rsp_dat_d;
         rsp_status_q <= rsp_status_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      sel_d        = sel_q;
      we_d         = we_q;
      timer_d      = timer_q;
      retry_d      = retry_q;
      rsp_valid_d  = 1'b0;
      rsp_dat_d    = rsp_dat_q;
      rsp_status_d = rsp_status_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               adr_d   = cmd_adr;
               dat_d   = cmd_dat;
               sel_d   = cmd_sel;
               we_d    = cmd_we;
               timer_d = '0;
               retry_d = '0;
               state_d = ST_BUS;
            end
         end

         ST_BUS: begin
            // err outranks rty, which outranks ack
            if (wb_err_i) begin
               state_d      = ST_IDLE;
               rsp_valid_d  = 1'b1;
               rsp_status_d = WB_ERR;
               rsp_dat_d    = '0;
            end else if (wb_rty_i) begin
               if (retry_q == RTY_MAX) begin
                  state_d      = ST_IDLE;
                  rsp_valid_d  = 1'b1;
                  rsp_status_d = WB_RTY_EXH;
                  rsp_dat_d    = '0;
               end else begin
                  retry_d = retry_q + RTY_W'(1);
                  state_d = ST_GAP;
               end
            end else if (wb_ack_i) begin
               state_d      = ST_IDLE;
               rsp_valid_d  = 1'b1;
               rsp_status_d = WB_OK;
               rsp_dat_d    = we_q ? '0 : wb_dat_i;
            end else if (timer_q == TMR_LAST) begin
               // timer counts 0..TIMEOUT_CYCLES-1, one value per BUS cycle
               state_d      = ST_IDLE;
               rsp_valid_d  = 1'b1;
               rsp_status_d = WB_TIMEOUT;
               rsp_dat_d    = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         ST_GAP: begin
            timer_d = '0;
            state_d = ST_BUS;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs: cyc/stb decode straight from state so reset drops them at once
   // ------------------------------------------------------------------------
   assign cmd_ready  = (state_q == ST_IDLE);
   assign wb_cyc_o   = (state_q == ST_BUS);
   assign wb_stb_o   = (state_q == ST_BUS);
   assign wb_adr_o   = adr_q;
   assign wb_dat_o   = dat_q;
   assign wb_sel_o   = sel_q;
   assign wb_we_o    = we_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_dat    = rsp_dat_q;
   assign rsp_status = rsp_status_q;

endmodule : wb_cmd_master
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_cmd_master
//  Purpose  : Self-checking bench for wb_cmd_master. A scripted slave answers
//             each attempt with a chosen termination after a chosen delay; a
//             transaction-level model predicts status, data and cycle counts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_cmd_master;

   localparam int DW = 32;
   localparam int AW = 6;
   localparam int SW = 4;
   localparam int T  = 16;
   localparam int MR = 3;

   // slave termination kinds
   localparam int K_ACK  = 0;
   localparam int K_ERR  = 1;
   localparam int K_RTY  = 2;
   localparam int K_NONE = 3;
   localparam int K_BOTH = 4;   // ack and err together

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_we = 1'b0;
   logic [AW-1:0] cmd_adr = '0;
   logic [DW-1:0] cmd_dat = '0;
   logic [SW-1:0] cmd_sel = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_dat;
   logic [1:0]    rsp_status;
   logic [AW-1:0] wb_adr_o;
   logic [DW-1:0] wb_dat_o;
   logic [DW-1:0] wb_dat_i;
   logic          wb_we_o;
   logic [SW-1:0] wb_sel_o;
   logic          wb_stb_o;
   logic          wb_cyc_o;
   logic          wb_ack_i;
   logic          wb_err_i;
   logic          wb_rty_i;

   always #5 clk = ~clk;

   wb_cmd_master #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .SELECT_WIDTH   (SW),
      .TIMEOUT_CYCLES (T),
      .MAX_RETRY      (MR)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_we     (cmd_we),
      .cmd_adr    (cmd_adr),
      .cmd_dat    (cmd_dat),
      .cmd_sel    (cmd_sel),
      .rsp_valid  (rsp_valid),
      .rsp_dat    (rsp_dat),
      .rsp_status (rsp_status),
      .wb_adr_o   (wb_adr_o),
      .wb_dat_o   (wb_dat_o),
      .wb_dat_i   (wb_dat_i),
      .wb_we_o    (wb_we_o),
      .wb_sel_o   (wb_sel_o),
      .wb_stb_o   (wb_stb_o),
      .wb_cyc_o   (wb_cyc_o),
      .wb_ack_i   (wb_ack_i),
      .wb_err_i   (wb_err_i),
      .wb_rty_i   (wb_rty_i)
   );

   // ------------------------------------------------------------------------
   // Scripted slave: attempt a terminates with kind_a[a] when its cycle
   // count reaches dly_a[a]; read data is a free-running counter.
   // ------------------------------------------------------------------------
   int          kind_a [8];
   int          dly_a  [8];
   int          att_idx = 0;
   int          att_cyc = 0;
   logic [31:0] cnt = 32'h0000_1000;

   assign wb_dat_i = cnt;

   always @(posedge clk) begin
      cnt <= cnt + 32'd1;
      if (cmd_valid && cmd_ready) begin
         att_idx <= 0;
         att_cyc <= 0;
      end else if (wb_cyc_o) begin
         if (wb_rty_i && !wb_err_i) begin
            att_idx <= att_idx + 1;
            att_cyc <= 0;
         end else begin
            att_cyc <= att_cyc + 1;
         end
      end
   end

   always_comb begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_rty_i = 1'b0;
      if (wb_cyc_o && att_idx < 8) begin
         if (att_cyc == dly_a[att_idx]) begin
            case (kind_a[att_idx])
               K_ACK:   wb_ack_i = 1'b1;
               K_ERR:   wb_err_i = 1'b1;
               K_RTY:   wb_rty_i = 1'b1;
               K_BOTH:  begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
               default: ;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Transaction-level prediction from the slave script. Cycle index 1 is
   // the first cycle after the accepting edge.
   task automatic model(output int st, output int c_ack, output int cyc_tot,
                        output int atts, output int c_rsp);
      int c;
      c       = 0;
      st      = 3;
      c_ack   = -1;
      cyc_tot = 0;
      atts    = 0;
      for (int a = 0; a <= MR; a++) begin
         atts++;
         if (kind_a[a] == K_NONE || dly_a[a] >= T) begin
            cyc_tot += T;
            c       += T;
            st       = 3;
            break;
         end
         cyc_tot += dly_a[a] + 1;
         c       += dly_a[a] + 1;
         if (kind_a[a] == K_ERR || kind_a[a] == K_BOTH) begin
            st = 1;
            break;
         end
         if (kind_a[a] == K_ACK) begin
            st    = 0;
            c_ack = c;
            break;
         end
         if (a == MR) begin
            st = 2;
            break;
         end
         c += 1;   // idle cycle before re-issue
      end
      c_rsp = c + 1;
   endtask

   // Issue one command (called at #1 after a clock edge with the DUT idle)
   task automatic run_txn(input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat, input logic [SW-1:0] sel);
      int          st, c_ack, cyc_tot, atts, c_rsp;
      int          i, cyc_hi, cyc_lo;
      logic        got, bus_bad;
      logic [DW-1:0] exp_dat;
      model(st, c_ack, cyc_tot, atts, c_rsp);
      chk_eq("ready_before_cmd", cmd_ready, 1);
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_sel   = sel;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      i = 1; got = 0; cyc_hi = 0; cyc_lo = 0; bus_bad = 0; exp_dat = '0;
      while (!got && i <= 200) begin
         if (wb_cyc_o) begin
            cyc_hi++;
            if (wb_adr_o !== adr || wb_dat_o !== dat || wb_sel_o !== sel ||
                wb_we_o !== we || wb_stb_o !== 1'b1)
               bus_bad = 1;
         end else begin
            if (wb_stb_o !== 1'b0) bus_bad = 1;
            if (!rsp_valid) cyc_lo++;
         end
         if (i == c_ack) exp_dat = cnt;
         if (rsp_valid) got = 1;
         else begin
            @(posedge clk); #1;
            i++;
         end
      end
      if (we || st != 0) exp_dat = '0;
      chk_eq("rsp_seen", got, 1);
      chk_eq("rsp_latency", i, c_rsp);
      chk_eq("rsp_status", rsp_status, st);
      chk_eq("rsp_dat", rsp_dat, exp_dat);
      chk_eq("cyc_high_cycles", cyc_hi, cyc_tot);
      chk_eq("cyc_gap_cycles", cyc_lo, atts - 1);
      chk_eq("bus_fields_stable", bus_bad, 0);
      chk_eq("ready_in_rsp_cycle", cmd_ready, 1);
      @(posedge clk); #1;
      chk_eq("rsp_single_pulse", rsp_valid, 0);
      chk_eq("rsp_status_hold", rsp_status, st);
      chk_eq("rsp_dat_hold", rsp_dat, exp_dat);
   endtask

   task automatic set_script(input int k0, input int d0, input int k1, input int d1,
                             input int k2, input int d2, input int k3, input int d3);
      kind_a[0] = k0; dly_a[0] = d0;
      kind_a[1] = k1; dly_a[1] = d1;
      kind_a[2] = k2; dly_a[2] = d2;
      kind_a[3] = k3; dly_a[3] = d3;
      for (int j = 4; j < 8; j++) begin
         kind_a[j] = K_NONE;
         dly_a[j]  = 0;
      end
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      int   d, k;
      logic saw_rsp, saw_cyc, exp_cyc;

      set_script(K_NONE, 0, K_NONE, 0, K_NONE, 0, K_NONE, 0);
      repeat (2) @(posedge clk);
      #1;
      chk_eq("reset_ready", cmd_ready, 1);
      chk_eq("reset_rsp_valid", rsp_valid, 0);
      chk_eq("reset_rsp_dat", rsp_dat, 0);
      chk_eq("reset_rsp_status", rsp_status, 0);
      chk_eq("reset_cyc", wb_cyc_o, 0);
      chk_eq("reset_stb", wb_stb_o, 0);
      chk_eq("reset_wb_fields", {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // write, combinational ack
      set_script(K_ACK, 0, K_NONE, 0, K_NONE, 0, K_NONE, 0);
      run_txn(1'b1, 6'h04, 32'hDEAD_BEEF, 4'hF);
      // read, ack two cycles in
      set_script(K_ACK, 2, K_NONE, 0, K_NONE, 0, K_NONE, 0);
      run_txn(1'b0, 6'h10, 32'h0, 4'hF);
      // retry on every attempt
      set_script(K_RTY, 1, K_RTY, 0, K_RTY, 2, K_RTY, 0);
      run_txn(1'b0, 6'h08, 32'h0, 4'h3);
      // retry once, then ack
      set_script(K_RTY, 0, K_ACK, 1, K_NONE, 0, K_NONE, 0);
      run_txn(1'b0, 6'h0C, 32'h0, 4'hF);
      // silent slave
      set_script(K_NONE, 0, K_NONE, 0, K_NONE, 0, K_NONE, 0);
      run_txn(1'b0, 6'h3F, 32'h0, 4'hF);
      // ack on the very last cycle before timeout
      set_script(K_ACK, T - 1, K_NONE, 0, K_NONE, 0, K_NONE, 0);
      run_txn(1'b0, 6'h01, 32'h0, 4'h1);
      // ack and err together
      set_script(K_BOTH, 1, K_NONE, 0, K_NONE, 0, K_NONE, 0);
      run_txn(1'b0, 6'h02, 32'h0, 4'hF);
      // retry then timeout on second attempt
      set_script(K_RTY, 3, K_NONE, 0, K_NONE, 0, K_NONE, 0);
      run_txn(1'b1, 6'h05, 32'h1234_5678, 4'hC);

      // randomized transactions
      for (int n = 0; n < 60; n++) begin
         for (int a = 0; a < 8; a++) begin
            k = int'($urandom_range(0, 9));
            if (k <= 3)      kind_a[a] = K_ACK;
            else if (k == 4) kind_a[a] = K_ERR;
            else if (k <= 7) kind_a[a] = K_RTY;
            else if (k == 8) kind_a[a] = K_NONE;
            else             kind_a[a] = K_BOTH;
            if ($urandom_range(0, 3) == 0) dly_a[a] = int'($urandom_range(0, T + 1));
            else                           dly_a[a] = int'($urandom_range(0, 3));
         end
         run_txn(1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom));
      end

      // reset in the middle of a bus cycle
      set_script(K_NONE, 0, K_NONE, 0, K_NONE, 0, K_NONE, 0);
      cmd_we = 1'b0; cmd_adr = 6'h22; cmd_sel = 4'hF; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_mid_cyc_before", wb_cyc_o, 1);
      rst_n = 1'b0;
      #1;
      chk_eq("rst_mid_cyc_drop", wb_cyc_o, 0);
      chk_eq("rst_mid_stb_drop", wb_stb_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      saw_rsp = 0; saw_cyc = 0;
      for (int j = 0; j < 20; j++) begin
         @(posedge clk); #1;
         saw_rsp |= rsp_valid;
         saw_cyc |= wb_cyc_o;
      end
      chk_eq("rst_mid_no_rsp", saw_rsp, 0);
      chk_eq("rst_mid_no_cyc", saw_cyc, 0);
      chk_eq("rst_mid_ready", cmd_ready, 1);

      // back-to-back with cmd_valid held high
      for (int r = 0; r < 3; r++) begin
         d = r * 2;
         set_script(K_ACK, d, K_ACK, d, K_ACK, d, K_ACK, d);
         for (int j = 4; j < 8; j++) begin
            kind_a[j] = K_ACK;
            dly_a[j]  = d;
         end
         cmd_we = 1'b1; cmd_adr = 6'h30; cmd_dat = 32'hA5A5_0000; cmd_sel = 4'hF;
         cmd_valid = 1'b1;
         @(posedge clk); #1;
         for (int j = 0; j < 4 * (d + 2); j++) begin
            exp_cyc = ((j % (d + 2)) != (d + 1));
            chk_eq("b2b_cyc", wb_cyc_o, exp_cyc);
            chk_eq("b2b_rsp_valid", rsp_valid, !exp_cyc);
            @(posedge clk); #1;
         end
         cmd_valid = 1'b0;
         for (int j = 0; j < 40 && !(cmd_ready && !rsp_valid); j++) begin
            @(posedge clk); #1;
         end
         chk_eq("b2b_drain_idle", cmd_ready, 1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // absolute guard against a stuck run
   initial begin
      #2000000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "bench time limit reached");
   end

endmodule : tb_wb_cmd_master
`default_nettype wire
